// File: rtl/opentdc_pkg.sv
// Shared constants for the multi-channel Wishbone TDC: register map,
// register bit positions, event entry layout and the pulse FSM states.
package opentdc_pkg;

    // Width of the channel number field in an event entry
    localparam int unsigned CHAN_W = 4;

    // Register word addresses (wbs_adr_i[4:2])
    localparam logic [2:0] ADR_STATUS   = 3'd0;
    localparam logic [2:0] ADR_CTRL     = 3'd1;
    localparam logic [2:0] ADR_TIME     = 3'd2;
    localparam logic [2:0] ADR_EVENT    = 3'd3;
    localparam logic [2:0] ADR_OUT_TIME = 3'd4;
    localparam logic [2:0] ADR_OUT_CTRL = 3'd5;

    // STATUS bit positions
    localparam int unsigned ST_EMPTY     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVF       = 2;
    localparam int unsigned ST_COUNT_LSB = 16;

    // CTRL bit positions (write-one actions)
    localparam int unsigned CTRL_OVF_CLR  = 16;
    localparam int unsigned CTRL_TIME_CLR = 31;

    // OUT_CTRL bit positions
    localparam int unsigned OCTRL_ARM = 0;

    // Event entry field offsets
    localparam int unsigned EV_VALID    = 31;
    localparam int unsigned EV_CHAN_LSB = 27;

    // One-shot output pulse sequencer
    typedef enum logic [1:0] {
        PULSE_IDLE   = 2'd0,
        PULSE_ARMED  = 2'd1,
        PULSE_ACTIVE = 2'd2
    } pulse_state_e;

endpackage

// File: rtl/opentdc_sfifo.sv
// Synchronous FIFO with occupancy count. A push while full is accepted
// only when a pop happens in the same cycle; a pop while empty is ignored.
module opentdc_sfifo #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/opentdc_wb_mc.sv
// Multi-channel Wishbone TDC front-end: synchronises pad inputs, stamps
// rising edges with a free-running counter, queues them in a shared FIFO
// and drives a programmable one-shot pulse on out_o.
module opentdc_wb_mc
    import opentdc_pkg::*;
#(
    parameter int unsigned NCHAN      = 3,
    parameter int unsigned TS_W       = 24,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned OUT_PULSE  = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_dat_i,
    input  logic [31:0]      wbs_adr_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [NCHAN-1:0] inp_i,
    output logic             out_o,
    output logic             irq_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FW    = CHAN_W + TS_W;
    localparam int unsigned PC_W  = (OUT_PULSE > 1) ? $clog2(OUT_PULSE) : 1;
    localparam logic [TS_W-1:0] TS_ONE = TS_W'(1);
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [TS_W-1:0]   time_q, time_d;
    logic [NCHAN-1:0]  en_q, en_d;
    logic [TS_W-1:0]   out_time_q, out_time_d;
    logic              ovf_q, ovf_d, ovf_set;
    logic [NCHAN-1:0]  rise, rise_en;
    logic [NCHAN-1:0]  pending_q, pending_d;
    logic [TS_W-1:0]   ts_q [NCHAN];
    logic [TS_W-1:0]   ts_d [NCHAN];

    logic              push_req;
    logic [CHAN_W-1:0] push_chan;
    logic [TS_W-1:0]   push_ts;

    logic              fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0]     fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;

    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic              irq_q, irq_d;
    logic              out_q, out_d;

    logic              wb_req, wb_acc, wb_wr, wb_rd;
    logic [2:0]        wb_adr;
    logic              ctrl_wr, time_clr, ovf_clr, arm_wr;
    logic [31:0]       rd_data;
    logic [31:0]       event_entry;

    pulse_state_e      state_q, state_d;
    logic [PC_W-1:0]   pcnt_q, pcnt_d;

    logic              unused_bits;
    assign unused_bits = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i};

    // ------------------------------------------------------------------
    // Wishbone decode: one access per ack, ack never back-to-back
    // ------------------------------------------------------------------
    assign wb_req   = wbs_stb_i & wbs_cyc_i;
    assign wb_acc   = wb_req & ~ack_q;
    assign wb_wr    = wb_acc & wbs_we_i;
    assign wb_rd    = wb_acc & ~wbs_we_i;
    assign wb_adr   = wbs_adr_i[4:2];
    assign ctrl_wr  = wb_wr & (wb_adr == ADR_CTRL);
    assign time_clr = ctrl_wr & wbs_sel_i[3] & wbs_dat_i[CTRL_TIME_CLR];
    assign ovf_clr  = ctrl_wr & wbs_sel_i[2] & wbs_dat_i[CTRL_OVF_CLR];
    assign arm_wr   = wb_wr & (wb_adr == ADR_OUT_CTRL) & wbs_sel_i[0];
    assign fifo_pop = wb_rd & (wb_adr == ADR_EVENT) & ~fifo_empty;

    // ------------------------------------------------------------------
    // Per-channel synchroniser and rising-edge detect
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        logic s1_q, s2_q, s3_q;

        // Two sync stages plus a history stage for edge detection
        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
                s3_q <= 1'b0;
            end else begin
                s1_q <= inp_i[g];
                s2_q <= s1_q;
                s3_q <= s2_q;
            end
        end

        assign rise[g] = s2_q & ~s3_q;
    end

    assign rise_en = rise & en_q;

    // ------------------------------------------------------------------
    // Fixed-priority arbiter: lowest pending channel pushes first
    // ------------------------------------------------------------------
    always_comb begin
        push_req  = 1'b0;
        push_chan = '0;
        push_ts   = '0;
        for (int unsigned i = 0; i < NCHAN; i++) begin
            if (pending_q[i] && !push_req) begin
                push_req  = 1'b1;
                push_chan = CHAN_W'(i);
                push_ts   = ts_q[i];
            end
        end
    end

    // Pending/timestamp capture and overflow detection
    always_comb begin
        pending_d = pending_q;
        ovf_set   = push_req & fifo_full & ~fifo_pop;
        for (int unsigned i = 0; i < NCHAN; i++) begin
            ts_d[i] = ts_q[i];
        end
        for (int unsigned i = 0; i < NCHAN; i++) begin
            // The arbitrated channel leaves pending whether pushed or dropped
            if (push_req && (push_chan == CHAN_W'(i))) pending_d[i] = 1'b0;
            if (rise_en[i]) begin
                if (pending_q[i]) begin
                    ovf_set = 1'b1;
                end else begin
                    pending_d[i] = 1'b1;
                    ts_d[i]      = time_q;
                end
            end
        end
        if (ovf_set)      ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
        else              ovf_d = ovf_q;
    end

    opentdc_sfifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (push_req),
        .data_i  ({push_chan, push_ts}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // ------------------------------------------------------------------
    // Time counter and writable registers
    // ------------------------------------------------------------------
    always_comb begin
        time_d     = time_clr ? '0 : (time_q + TS_ONE);
        en_d       = en_q;
        out_time_d = out_time_q;
        for (int unsigned i = 0; i < NCHAN; i++) begin
            if (ctrl_wr && wbs_sel_i[i / 8]) en_d[i] = wbs_dat_i[i];
        end
        for (int unsigned i = 0; i < TS_W; i++) begin
            if (wb_wr && (wb_adr == ADR_OUT_TIME) && wbs_sel_i[i / 8]) out_time_d[i] = wbs_dat_i[i];
        end
    end

    // ------------------------------------------------------------------
    // Read data mux and event entry formatting
    // ------------------------------------------------------------------
    always_comb begin
        event_entry                                = '0;
        event_entry[EV_VALID]                      = 1'b1;
        event_entry[EV_CHAN_LSB +: CHAN_W]         = fifo_rdata[FW-1 -: CHAN_W];
        event_entry[TS_W-1:0]                      = fifo_rdata[TS_W-1:0];

        rd_data = '0;
        case (wb_adr)
            ADR_STATUS: begin
                rd_data[ST_COUNT_LSB +: 16] = 16'(fifo_count);
                rd_data[ST_OVF]             = ovf_q;
                rd_data[ST_FULL]            = fifo_full;
                rd_data[ST_EMPTY]           = fifo_empty;
            end
            ADR_CTRL:     rd_data = 32'(en_q);
            ADR_TIME:     rd_data = 32'(time_q);
            ADR_EVENT:    rd_data = fifo_empty ? '0 : event_entry;
            ADR_OUT_TIME: rd_data = 32'(out_time_q);
            ADR_OUT_CTRL: rd_data[OCTRL_ARM] = (state_q == PULSE_ARMED);
            default:      rd_data = '0;
        endcase

        ack_d = wb_acc;
        dat_d = wb_rd ? rd_data : '0;
        irq_d = ~fifo_empty;
    end

    // ------------------------------------------------------------------
    // Pulse sequencer: IDLE -> ARMED -> ACTIVE(OUT_PULSE cycles) -> IDLE
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        case (state_q)
            PULSE_IDLE: begin
                if (arm_wr && wbs_dat_i[OCTRL_ARM]) state_d = PULSE_ARMED;
            end
            PULSE_ARMED: begin
                if (arm_wr && !wbs_dat_i[OCTRL_ARM]) begin
                    state_d = PULSE_IDLE;
                end else if (time_q == out_time_q) begin
                    state_d = PULSE_ACTIVE;
                    pcnt_d  = PC_W'(OUT_PULSE - 1);
                end
            end
            PULSE_ACTIVE: begin
                if (pcnt_q == '0) state_d = PULSE_IDLE;
                else              pcnt_d  = pcnt_q - PC_ONE;
            end
            default: state_d = PULSE_IDLE;
        endcase
        out_d = (state_d == PULSE_ACTIVE);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // Counter, configuration, capture and WB response registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            time_q     <= '0;
            en_q       <= '0;
            out_time_q <= '0;
            ovf_q      <= 1'b0;
            pending_q  <= '0;
            for (int unsigned i = 0; i < NCHAN; i++) ts_q[i] <= '0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            irq_q      <= 1'b0;
            out_q      <= 1'b0;
            state_q    <= PULSE_IDLE;
            pcnt_q     <= '0;
        end else begin
            time_q     <= time_d;
            en_q       <= en_d;
            out_time_q <= out_time_d;
            ovf_q      <= ovf_d;
            pending_q  <= pending_d;
            for (int unsigned i = 0; i < NCHAN; i++) ts_q[i] <= ts_d[i];
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            irq_q      <= irq_d;
            out_q      <= out_d;
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;
    assign out_o     = out_q;

endmodule

// File: tb/tb_opentdc_wb_mc.sv
// Self-checking bench for opentdc_wb_mc: a 24-bit-timestamp instance and an
// 8-bit-timestamp instance share one Wishbone bus and input pads.
module tb_opentdc_wb_mc;
    import opentdc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] wdat, adr;
    logic [2:0]  inp;
    logic        ack, out, irq;
    logic [31:0] rdat;
    logic        ack8, out8, irq8;
    logic [31:0] rdat8;

    int unsigned edge_n = 0;
    int          checks = 0;
    int          errors = 0;
    int unsigned clr_edge = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    opentdc_wb_mc #(
        .NCHAN(3), .TS_W(24), .FIFO_DEPTH(16), .OUT_PULSE(4)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_dat_o(rdat), .inp_i(inp), .out_o(out), .irq_o(irq)
    );

    opentdc_wb_mc #(
        .NCHAN(3), .TS_W(8), .FIFO_DEPTH(16), .OUT_PULSE(4)
    ) dut8 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr),
        .wbs_ack_o(ack8), .wbs_dat_o(rdat8), .inp_i(inp), .out_o(out8), .irq_o(irq8)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Expected event entry: stamp is the counter value two edges after the
    // first sampling edge (input driven after edge n, sampled at n+1).
    function automatic logic [31:0] ev(input int unsigned ch, input int unsigned n);
        logic [23:0] ts;
        ts = 24'(n + 2 - clr_edge);
        return {1'b1, 4'(ch), 3'b000, ts};
    endfunction

    task automatic wb_access(input logic w, input logic [2:0] a, input logic [31:0] d_in,
                             output logic [31:0] d, output logic [31:0] d8, output int unsigned e);
        int waited;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = w; sel = 4'hF; wdat = d_in;
        adr = {27'b0, a, 2'b00};
        waited = 0;
        while (waited < 4) begin
            @(posedge clk); #1;
            waited++;
            if (ack) break;
        end
        checks++;
        if (!ack || waited != 1) begin
            errors++;
            $display("FAIL wb_ack_latency adr=%0d got_edges=%0d ack=%b expected 1 edge", a, waited, ack);
        end
        d = rdat; d8 = rdat8; e = edge_n;
        stb = 1'b0; cyc = 1'b0; we = 1'b0; wdat = '0;
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] d, output logic [31:0] d8,
                           output int unsigned e);
        wb_access(1'b0, a, 32'h0, d, d8, e);
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] v, output int unsigned e);
        logic [31:0] d, d8;
        wb_access(1'b1, a, v, d, d8, e);
    endtask

    task automatic drive_rise(input logic [2:0] mask, input logic expect_push);
        @(posedge clk); #1;
        inp = mask;
        if (expect_push)
            for (int unsigned c = 0; c < 3; c++)
                if (mask[c]) exp_q.push_back(ev(c, edge_n));
        repeat (2) @(posedge clk);
        #1 inp = '0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d, d8, exp;
        int unsigned e;
        rst = 1'b1; stb = 0; cyc = 0; we = 0; sel = 0; wdat = 0; adr = 0; inp = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ack, rdat, out, irq} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b dat=%h out=%b irq=%b expected all 0", ack, rdat, out, irq);
        end
        rst = 1'b0;
        clr_edge = edge_n;
        wb_read(ADR_STATUS, d, d8, e);
        checks++;
        if (d !== 32'h0000_0001) begin errors++; $display("FAIL reset_status got %h expected 00000001", d); end
        wb_read(ADR_EVENT, d, d8, e);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_event_empty got %h expected 00000000", d); end
        wb_read(ADR_TIME, d, d8, e);
        exp = 32'(e - clr_edge - 1);
        checks++;
        if (d !== exp) begin errors++; $display("FAIL reset_time got %h expected %h", d, exp); end
    endtask

    task automatic test_single_event();
        logic [31:0] d, d8, exp;
        int unsigned e;
        wb_write(ADR_CTRL, 32'h8000_0007, e);
        clr_edge = e;
        wb_read(ADR_CTRL, d, d8, e);
        checks++;
        if (d !== 32'h7) begin errors++; $display("FAIL ctrl_readback got %h expected 00000007", d); end
        drive_rise(3'b010, 1'b1);
        wb_read(ADR_STATUS, d, d8, e);
        checks++;
        if (d !== 32'h0001_0000) begin errors++; $display("FAIL single_status got %h expected 00010000", d); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL single_irq_high got %b expected 1", irq); end
        wb_read(ADR_EVENT, d, d8, e);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (d !== exp) begin errors++; $display("FAIL single_event got %h expected %h", d, exp); end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_low got %b expected 0", irq); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d, d8, exp;
        int unsigned e;
        drive_rise(3'b101, 1'b1);
        wb_read(ADR_STATUS, d, d8, e);
        checks++;
        if (d !== 32'h0002_0000) begin errors++; $display("FAIL same_cycle_status got %h expected 00020000", d); end
        for (int i = 0; i < 2; i++) begin
            wb_read(ADR_EVENT, d, d8, e);
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (d !== exp) begin errors++; $display("FAIL same_cycle_event%0d got %h expected %h", i, d, exp); end
        end
        wb_write(3'd7, 32'hFFFF_FFFF, e);
        wb_read(3'd6, d, d8, e);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h expected 00000000", d); end
        wb_read(ADR_STATUS, d, d8, e);
        checks++;
        if (d !== 32'h0000_0001) begin errors++; $display("FAIL same_cycle_drained got %h expected 00000001", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d, d8, exp;
        int unsigned e;
        for (int i = 0; i < 17; i++) drive_rise(3'b001, (i < 16));
        wb_read(ADR_STATUS, d, d8, e);
        checks++;
        if (d !== 32'h0010_0006) begin errors++; $display("FAIL ovf_status got %h expected 00100006", d); end
        wb_write(ADR_CTRL, 32'h0001_0007, e);
        wb_read(ADR_STATUS, d, d8, e);
        checks++;
        if (d !== 32'h0010_0002) begin errors++; $display("FAIL ovf_cleared got %h expected 00100002", d); end
        for (int i = 0; i < 16; i++) begin
            wb_read(ADR_EVENT, d, d8, e);
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (d !== exp) begin errors++; $display("FAIL ovf_entry%0d got %h expected %h", i, d, exp); end
        end
        wb_read(ADR_STATUS, d, d8, e);
        checks++;
        if (d !== 32'h0000_0001) begin errors++; $display("FAIL ovf_drained got %h expected 00000001", d); end
    endtask

    task automatic test_pulse();
        logic [31:0] d, d8;
        int unsigned e;
        logic exp_o;
        int highs;
        wb_write(ADR_OUT_TIME, 32'd100, e);
        wb_write(ADR_CTRL, 32'h8000_0007, e);
        clr_edge = e;
        wb_write(ADR_OUT_CTRL, 32'h1, e);
        wb_read(ADR_OUT_CTRL, d, d8, e);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL pulse_armed got %h expected 00000001", d); end
        while (edge_n < clr_edge + 110) begin
            @(posedge clk); #1;
            exp_o = (edge_n >= clr_edge + 101) && (edge_n <= clr_edge + 104);
            checks++;
            if (out !== exp_o) begin
                errors++;
                $display("FAIL pulse_out t=%0d got %b expected %b", edge_n - clr_edge, out, exp_o);
            end
        end
        wb_read(ADR_OUT_CTRL, d, d8, e);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL pulse_autoclear got %h expected 00000000", d); end
        // Disarming before the match must suppress the pulse
        wb_write(ADR_OUT_TIME, 32'd40, e);
        wb_write(ADR_CTRL, 32'h8000_0007, e);
        clr_edge = e;
        wb_write(ADR_OUT_CTRL, 32'h1, e);
        wb_write(ADR_OUT_CTRL, 32'h0, e);
        highs = 0;
        while (edge_n < clr_edge + 60) begin
            @(posedge clk); #1;
            if (out) highs++;
        end
        checks++;
        if (highs != 0) begin errors++; $display("FAIL pulse_cancel got %0d high cycles expected 0", highs); end
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] d, d8, exp, exp8, prev8;
        int unsigned e;
        logic wrapped;
        wb_write(ADR_CTRL, 32'h8000_0007, e);
        clr_edge = e;
        while (edge_n < clr_edge + 240) @(posedge clk);
        prev8 = '0;
        wrapped = 1'b0;
        while (edge_n < clr_edge + 270) begin
            wb_read(ADR_TIME, d, d8, e);
            exp  = 32'(e - clr_edge - 1);
            exp8 = exp & 32'hFF;
            checks++;
            if (d !== exp || d8 !== exp8) begin
                errors++;
                $display("FAIL time_wrap got %h/%h expected %h/%h", d, d8, exp, exp8);
            end
            if (d8 < prev8) wrapped = 1'b1;
            prev8 = d8;
        end
        checks++;
        if (!wrapped) begin errors++; $display("FAIL time_wrap_seen got 0 expected 1"); end

        // Reset in the middle of a pending EVENT read with a non-empty FIFO
        drive_rise(3'b001, 1'b0);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = {27'b0, ADR_EVENT, 2'b00};
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({ack, rdat, out, irq, ack8, rdat8, out8, irq8} !== 70'd0) begin
                errors++;
                $display("FAIL reset_mid_read got ack=%b dat=%h irq=%b ack8=%b irq8=%b expected all 0",
                         ack, rdat, irq, ack8, irq8);
            end
        end
        stb = 1'b0; cyc = 1'b0;
        rst = 1'b0;
        wb_read(ADR_STATUS, d, d8, e);
        checks++;
        if (d !== 32'h1 || d8 !== 32'h1) begin
            errors++;
            $display("FAIL reset_mid_status got %h/%h expected 00000001/00000001", d, d8);
        end
        wb_read(ADR_CTRL, d, d8, e);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_mid_ctrl got %h expected 00000000", d); end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_same_cycle();
        test_overflow();
        test_pulse();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
